// File: rtl/imm_decode_stage.sv
// Registered RV immediate decoder with a valid/ready handshake and a 2-entry skid buffer.
// Optional IMM_DECODE_ZICSR_EN: SYSTEM opcodes with instr[14]=1 decode as CSR (fmt 6, zext rs1/uimm).
module imm_decode_stage #(
  parameter int DW = 32,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [DW-1:0] out_imm,
  output logic [2:0]    out_fmt,
  output logic          out_illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
`ifdef IMM_DECODE_ZICSR_EN
  localparam logic [2:0] FMT_CSR = 3'd6;
`endif

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [DW-1:0] imm;
    logic [2:0]    fmt;
    logic          ill;
  } entry_t;

  entry_t      dec;
  logic [31:0] imm32;
  entry_t      main_q, main_d, skid_q, skid_d;
  logic        main_valid_q, main_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        in_ready_q, in_ready_d;
  logic        accept, drain;

  always_comb begin
    imm32     = 32'h0;
    dec.fmt   = FMT_R;
    dec.ill   = 1'b0;
    dec.instr = in_instr;
    unique case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b0001111: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b1110011: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
`ifdef IMM_DECODE_ZICSR_EN
        if (in_instr[14]) begin
          dec.fmt = FMT_CSR;
          imm32   = {27'h0, in_instr[19:15]};
        end
`endif
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'h0};
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0110011, 7'b0111011: dec.fmt = FMT_R;
      // Opcode match already implies instr[1:0]==2'b11, so this also covers compressed encodings.
      default: dec.ill = 1'b1;
    endcase
    // imm32 is already sign-correct at 32 bits; widen from its MSB.
    dec.imm       = {DW{imm32[31]}};
    dec.imm[31:0] = imm32;
  end

  assign accept = in_valid & in_ready_q;
  assign drain  = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      // accept is impossible while skid is occupied, so skid promotion never races a new input.
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = dec;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_instr   = main_q.instr;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.ill;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: formats at DW=32/64, backpressure, flush, async reset.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;

  logic        in_valid_w = 1'b0;
  logic        in_ready_w;
  logic [31:0] in_instr_w = 32'h0;
  logic        out_valid_w;
  logic [31:0] out_instr_w;
  logic [63:0] out_imm_w;
  logic [2:0]  out_fmt_w;
  logic        out_illegal_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.DW(32), .IW(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  imm_decode_stage #(.DW(64), .IW(32)) dut_w (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(in_valid_w), .in_ready(in_ready_w), .in_instr(in_instr_w),
    .out_valid(out_valid_w), .out_ready(1'b1), .out_instr(out_instr_w),
    .out_imm(out_imm_w), .out_fmt(out_fmt_w), .out_illegal(out_illegal_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_instr"}, 64'(out_instr), 64'd0);
    check({tag, "_out_imm"}, 64'(out_imm), 64'd0);
    check({tag, "_out_fmt"}, 64'(out_fmt), 64'd0);
    check({tag, "_out_illegal"}, 64'(out_illegal), 64'd0);
  endtask

  logic [31:0] vin [9];
  logic [31:0] vimm[9];
  logic [2:0]  vfmt[9];
  logic        vill[9];
  logic [31:0] bp  [4];

  initial begin
    vin[0] = 32'hFFF00093; vimm[0] = 32'hFFFFFFFF; vfmt[0] = 3'd1; vill[0] = 1'b0;
    vin[1] = 32'hFE112E23; vimm[1] = 32'hFFFFFFFC; vfmt[1] = 3'd2; vill[1] = 1'b0;
    vin[2] = 32'hFE000CE3; vimm[2] = 32'hFFFFFFF8; vfmt[2] = 3'd3; vill[2] = 1'b0;
    vin[3] = 32'h123450B7; vimm[3] = 32'h12345000; vfmt[3] = 3'd4; vill[3] = 1'b0;
    vin[4] = 32'h0010006F; vimm[4] = 32'h00000800; vfmt[4] = 3'd5; vill[4] = 1'b0;
    vin[5] = 32'h00000033; vimm[5] = 32'h00000000; vfmt[5] = 3'd0; vill[5] = 1'b0;
    vin[6] = 32'h00000010; vimm[6] = 32'h00000000; vfmt[6] = 3'd0; vill[6] = 1'b1;
    vin[7] = 32'h0000007F; vimm[7] = 32'h00000000; vfmt[7] = 3'd0; vill[7] = 1'b1;
`ifdef IMM_DECODE_ZICSR_EN
    vin[8] = 32'h3002D073; vimm[8] = 32'h00000005; vfmt[8] = 3'd6; vill[8] = 1'b0;
`else
    vin[8] = 32'h3002D073; vimm[8] = 32'h00000300; vfmt[8] = 3'd1; vill[8] = 1'b0;
`endif
    bp[0] = 32'h00100093; bp[1] = 32'h00200113; bp[2] = 32'h00300193; bp[3] = 32'h00400213;

    // Reset held across clock edges, then outputs must show reset values.
    repeat (2) step();
    check_reset_outputs("rst0");
    rst_n = 1'b1;

    // Back-to-back formats, out_ready held high: each result one cycle after its accept.
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_instr = vin[i];
      step();
      check($sformatf("fmt%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("fmt%0d_instr", i), 64'(out_instr), 64'(vin[i]));
      check($sformatf("fmt%0d_imm", i), 64'(out_imm), 64'(vimm[i]));
      check($sformatf("fmt%0d_fmt", i), 64'(out_fmt), 64'(vfmt[i]));
      check($sformatf("fmt%0d_ill", i), 64'(out_illegal), 64'(vill[i]));
      check($sformatf("fmt%0d_in_ready", i), 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    step();
    check("drain_empty", 64'(out_valid), 64'd0);

    // DW=64 sign extension.
    in_valid_w = 1'b1;
    in_instr_w = 32'h800000B7;
    step();
    check("w64_u_valid", 64'(out_valid_w), 64'd1);
    check("w64_u_imm", out_imm_w, 64'hFFFFFFFF80000000);
    check("w64_u_fmt", 64'(out_fmt_w), 64'd4);
    in_instr_w = 32'hFE000CE3;
    step();
    check("w64_b_imm", out_imm_w, 64'hFFFFFFFFFFFFFFF8);
    check("w64_b_fmt", 64'(out_fmt_w), 64'd3);
    in_valid_w = 1'b0;

    // Backpressure: 3 stalled cycles, then drain; order and count must hold.
    begin
      int k = 0;
      int pops = 0;
      logic acc, drn;
      logic [31:0] seen;
      for (int cyc = 0; cyc < 20 && pops < 4; cyc++) begin
        out_ready = (cyc >= 3);
        in_valid  = (k < 4);
        in_instr  = bp[(k < 4) ? k : 0];
        acc  = in_valid && in_ready;
        drn  = out_valid && out_ready;
        seen = out_instr;
        step();
        if (drn) begin
          check($sformatf("bp_order%0d", pops), 64'(seen), 64'(bp[pops]));
          pops++;
        end
        if (acc) k++;
        if (cyc == 0) check("bp_in_ready_after_1st", 64'(in_ready), 64'd1);
        if (cyc == 1) check("bp_in_ready_after_2nd", 64'(in_ready), 64'd0);
        if (cyc == 2) check("bp_stable", 64'(out_instr), 64'(bp[0]));
        if (cyc == 3) check("bp_in_ready_back", 64'(in_ready), 64'd1);
      end
      in_valid = 1'b0;
      check("bp_count", 64'(pops), 64'd4);
    end
    step();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Flush with both entries occupied and input pending.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h11111093;
    step();
    in_instr  = 32'h22222113;
    step();
    check("fl_full_in_ready", 64'(in_ready), 64'd0);
    in_instr  = 32'h33333193;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (2) step();
    check("fl_nothing_emerges", 64'(out_valid), 64'd0);

    // Flush discards a same-cycle accepted input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h44444293;
    step();
    in_instr  = 32'h55555313;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    check("fl2_out_valid", 64'(out_valid), 64'd0);
    check("fl2_in_ready", 64'(in_ready), 64'd1);
    step();
    check("fl2_still_empty", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-cycle with the skid full and input still offered.
    in_valid = 1'b1;
    in_instr = 32'hFE112E23;
    step();
    in_instr = 32'h123450B7;
    step();
    check("ar_skid_full", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("ar");
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    in_instr  = 32'h0010006F;
    step();
    in_valid  = 1'b0;
    check("ar_first_valid", 64'(out_valid), 64'd1);
    check("ar_first_instr", 64'(out_instr), 64'h0010006F);
    check("ar_first_imm", 64'(out_imm), 64'h00000800);
    step();
    check("ar_done_empty", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered immediate-decode stage for the single-cycle and upcoming pipelined cores. It derives the instruction format from the opcode; callers no longer supply one-hot type flags. It produces the correctly bit-scrambled, sign-extended immediate for every RV base format at a parametrised data width. The stage sits between fetch and register read, with a valid/ready handshake on both sides and a 2-entry skid buffer so it sustains one instruction per cycle under backpressure.

## Interface

Parameters:
- `DW`, 32, immediate/data width; legal values 32 or 64.
- `IW`, 32, instruction width; fixed at 32.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous kill of all held entries.
- `in_valid`  in  1  upstream instruction valid.
- `in_ready`  out  1  stage can accept.
- `in_instr`  in  IW  raw instruction.
- `out_valid`  out  1  decoded entry valid.
- `out_ready`  in  1  downstream accepts.
- `out_instr`  out  IW  instruction passed through.
- `out_imm`  out  DW  extended immediate.
- `out_fmt`  out  3  format: 0 NONE/R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR.
- `out_illegal`  out  1  `in_instr[1:0]`≠2'b11 or unknown opcode.

## Operation

- Decode by `instr[6:0]`; sext = sign-extend from `instr[31]` to DW:
  - I (0000011, 0010011, 0011011, 1100111, 0001111, 1110011): sext(`instr[31:20]`).
  - S (0100011): sext({`[31:25]`, `[11:7]`}).
  - B (1100011): sext({`[31]`, `[7]`, `[30:25]`, `[11:8]`, 0}).
  - U (0110111, 0010111): sext({`[31:12]`, 12'h0}).
  - J (1101111): sext({`[31]`, `[19:12]`, `[20]`, `[30:21]`, 0}).
  - R (0110011, 0111011): fmt 0, imm 0.
- Any other opcode, or low bits ≠2'b11: fmt 0, imm 0, `out_illegal`=1.
- Decode is combinational on the input side. The result is registered into the main entry, or into the skid entry when the main entry is held.
- `in_ready` = skid entry empty; it is a registered signal.
- The output always presents the main entry. When the main entry drains, the skid entry moves into main in the same edge.

## Timing

- Latency 1: an instruction accepted at edge N is on the outputs after N, with `out_valid`=1.
- With `out_ready`=1 held, throughput is 1/cycle and the skid entry stays empty.
- Main entry valid with `out_ready`=0 and an input handshake: the input goes into skid, and `in_ready` drops after that edge.
- Main and skid both valid: `in_ready`=0 until a drain. The drain frees skid, and `in_ready`=1 the following cycle.
- Simultaneous drain and accept with skid empty: main reloads with the new entry, and `out_valid` stays 1.
- `flush`=1 at an edge: both entries are invalidated and any same-cycle input handshake is discarded. Next cycle `out_valid`=0 and `in_ready`=1.
- Reset (async, any time, mid-handshake included): `out_valid`=0, `in_ready`=1, `out_instr`=0, `out_imm`=0, `out_fmt`=0, `out_illegal`=0, skid empty.
- Outputs are stable while `out_valid`=1 and `out_ready`=0.

## Configuration

- `IMM_DECODE_ZICSR_EN` defined: opcode 1110011 with `instr[14]`=1 decodes as fmt 6 CSR, imm = zero-extend(`instr[19:15]`). With `instr[14]`=0 it stays I.
- Not defined: all of 1110011 decodes as I, and fmt 6 is never produced.

## Test plan

- Formats, DW=32, one per cycle, `out_ready`=1 → 1-cycle latency each:
  - 0xFFF00093 → imm 0xFFFFFFFF, fmt 1.
  - 0xFE112E23 → 0xFFFFFFFC, fmt 2.
  - 0xFE000CE3 → 0xFFFFFFF8, fmt 3.
  - 0x123450B7 → 0x12345000, fmt 4.
  - 0x0010006F → 0x00000800, fmt 5.
- DW=64: 0x800000B7 → 0xFFFFFFFF80000000. 0x00000033 → imm 0, fmt 0, illegal 0. 0x00000013 with `[1:0]` forced to 00 → illegal 1.
- Backpressure: stream 4 instrs, `out_ready`=0 for 3 cycles. Required: `in_ready` drops after the 2nd accept, no loss or reorder, all 4 emerge in order once `out_ready`=1.
- Flush with both entries full plus `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1, and the flushed input never appears.
- 0x3002D073: with `IMM_DECODE_ZICSR_EN`, imm 5, fmt 6. Without it, imm 0x00000300, fmt 1.
- `rst_n` pulsed low while skid is full → all outputs at reset values immediately. After release, the first new input emerges with latency 1.
